// File: rtl/btb_nway.sv
// btb_nway: set-associative branch target buffer.
// The buffer has a registered lookup port, an allocate/overwrite port and a retire
// port that updates the direction counters. Replacement uses a tree pseudo-LRU
// (PLRU). A two-state FSM invalidates one set per cycle during a flush.
module btb_nway #(
    parameter int WAYS  = 4,
    parameter int SETS  = 256,
    parameter int TAG_W = 20
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      rd_vld_i,
    input  logic [63:0]               rd_pc_i,
    input  logic                      up_we_i,
    input  logic [63:0]               up_pc_i,
    input  logic [2:0]                up_pos_i,
    input  logic [1:0]                up_typ_i,
    input  logic [63:0]               up_tar_i,
    input  logic                      rt_we_i,
    input  logic [63:0]               rt_pc_i,
    input  logic                      rt_dir_i,
    input  logic                      flush_i,
    output logic                      busy_o,
    output logic                      hit_o,
    output logic [$clog2(WAYS)-1:0]   hit_way_o,
    output logic [2:0]                br_pos_o,
    output logic [1:0]                br_typ_o,
    output logic [63:0]               br_tar_o,
    output logic                      br_dir_o
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_LO = IDX_W + 2;
    localparam int TAG_HI = IDX_W + TAG_W + 1;

    typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

    // Storage: tag and payload need no reset. Valid, counter and PLRU bits do.
    logic [TAG_W-1:0] tag_mem [SETS][WAYS];
    logic [2:0]       pos_mem [SETS][WAYS];
    logic [1:0]       typ_mem [SETS][WAYS];
    logic [63:0]      tar_mem [SETS][WAYS];
    logic [WAYS-1:0]  valid_reg [SETS];
    logic [1:0]       ctr_reg [SETS][WAYS];
    logic [WAYS-2:0]  plru_reg [SETS];

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] flush_ctr_reg, flush_ctr_next;
    logic             flush_act;

    // Index and tag fields of the three PC ports.
    logic [IDX_W-1:0] rd_idx, up_idx, rt_idx;
    logic [TAG_W-1:0] rd_tag, up_tag, rt_tag;
    assign rd_idx = rd_pc_i[IDX_W+1:2];
    assign up_idx = up_pc_i[IDX_W+1:2];
    assign rt_idx = rt_pc_i[IDX_W+1:2];
    assign rd_tag = rd_pc_i[TAG_HI:TAG_LO];
    assign up_tag = up_pc_i[TAG_HI:TAG_LO];
    assign rt_tag = rt_pc_i[TAG_HI:TAG_LO];

    // PC bits outside the index and tag fields carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{rd_pc_i[63:TAG_HI+1], rd_pc_i[1:0],
                              up_pc_i[63:TAG_HI+1], up_pc_i[1:0],
                              rt_pc_i[63:TAG_HI+1], rt_pc_i[1:0]};

    // Return the lowest set bit as {found, index}.
    function automatic logic [WAY_W:0] lowest_one(input logic [WAYS-1:0] v);
        logic [WAY_W:0] r;
        r = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (v[w]) r = {1'b1, WAY_W'(w)};
        end
        return r;
    endfunction

    // Mark a way as used. Each node on its path is set to point at the other subtree.
    // Nodes use heap order: node n has children 2n+1 (bit 0) and 2n+2 (bit 1).
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] way);
        logic [WAYS-1:0]  res;
        logic [WAY_W-1:0] sh;
        logic             dir;
        int               nd;
        res = {1'b0, bits};
        sh  = way;
        nd  = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = sh[WAY_W-1];
            sh  = sh << 1;
            res[nd[WAY_W-1:0]] = ~dir;
            nd  = 2 * nd + 1 + (dir ? 1 : 0);
        end
        return res[WAYS-2:0];
    endfunction

    // Follow the PLRU bits from the root down to the victim leaf.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
        logic [WAYS-1:0]  b;
        logic [WAY_W-1:0] way;
        logic             dir;
        int               nd;
        b   = {1'b0, bits};
        way = '0;
        nd  = 0;
        for (int l = 0; l < WAY_W; l++) begin
            dir = b[nd[WAY_W-1:0]];
            way = (way << 1) | WAY_W'(dir);
            nd  = 2 * nd + 1 + (dir ? 1 : 0);
        end
        return way;
    endfunction

    // Per-way tag compare for each port.
    logic [WAYS-1:0] rd_match, up_match, up_free, rt_match;
    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_match
            assign rd_match[gi] = valid_reg[rd_idx][gi] && (tag_mem[rd_idx][gi] == rd_tag);
            assign up_match[gi] = valid_reg[up_idx][gi] && (tag_mem[up_idx][gi] == up_tag);
            assign up_free[gi]  = ~valid_reg[up_idx][gi];
            assign rt_match[gi] = valid_reg[rt_idx][gi] && (tag_mem[rt_idx][gi] == rt_tag);
        end
    endgenerate

    logic [WAY_W:0]   rd_enc, up_enc, free_enc, rt_enc;
    logic             rd_hit, rt_hit;
    logic [WAY_W-1:0] rd_way, rt_way, up_vic;
    logic [1:0]       rt_ctr_cur, rt_ctr_next;
    logic             lookup_ok, up_ok, rt_ok;

    // Hit ways and allocation victim choice: matching way, else lowest free way, else PLRU.
    always_comb begin
        rd_enc   = lowest_one(rd_match);
        up_enc   = lowest_one(up_match);
        free_enc = lowest_one(up_free);
        rt_enc   = lowest_one(rt_match);
        rd_hit   = rd_enc[WAY_W];
        rd_way   = rd_enc[WAY_W-1:0];
        rt_hit   = rt_enc[WAY_W];
        rt_way   = rt_enc[WAY_W-1:0];
        if (up_enc[WAY_W])
            up_vic = up_enc[WAY_W-1:0];
        else if (free_enc[WAY_W])
            up_vic = free_enc[WAY_W-1:0];
        else
            up_vic = plru_victim(plru_reg[up_idx]);
        lookup_ok = rd_vld_i && !flush_act;
        up_ok     = up_we_i && !flush_act;
        rt_ok     = rt_we_i && rt_hit && !flush_act;
    end

    // Retire counter: saturate at 3 when taken and at 0 when not taken.
    always_comb begin
        rt_ctr_cur  = ctr_reg[rt_idx][rt_way];
        rt_ctr_next = rt_ctr_cur;
        if (rt_dir_i && rt_ctr_cur != 2'b11)
            rt_ctr_next = rt_ctr_cur + 2'b01;
        else if (!rt_dir_i && rt_ctr_cur != 2'b00)
            rt_ctr_next = rt_ctr_cur - 2'b01;
    end

    // FSM state register and flush counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            flush_ctr_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_ctr_reg <= flush_ctr_next;
        end
    end

    // FSM next state: a flush walks every set once. flush_i is ignored while a flush runs.
    always_comb begin
        state_next     = state_reg;
        flush_ctr_next = flush_ctr_reg;
        case (state_reg)
            IDLE: begin
                if (flush_i) begin
                    state_next     = FLUSH;
                    flush_ctr_next = '0;
                end
            end
            FLUSH: begin
                if (flush_ctr_reg == IDX_W'(SETS - 1))
                    state_next = IDLE;
                else
                    flush_ctr_next = flush_ctr_reg + 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        flush_act = (state_reg == FLUSH);
        busy_o    = flush_act;
    end

    // Valid, counter and PLRU state. A later assignment overrides an earlier one.
    // So allocation beats retire on the same way, and beats a lookup hit on the PLRU.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SETS; s++) begin
                valid_reg[s] <= '0;
                plru_reg[s]  <= '0;
                for (int w = 0; w < WAYS; w++) ctr_reg[s][w] <= 2'b00;
            end
        end else if (flush_act) begin
            valid_reg[flush_ctr_reg] <= '0;
            plru_reg[flush_ctr_reg]  <= '0;
        end else begin
            if (rt_ok)
                ctr_reg[rt_idx][rt_way] <= rt_ctr_next;
            if (lookup_ok && rd_hit)
                plru_reg[rd_idx] <= plru_touch(plru_reg[rd_idx], rd_way);
            if (up_ok) begin
                valid_reg[up_idx][up_vic] <= 1'b1;
                ctr_reg[up_idx][up_vic]   <= 2'b10;
                plru_reg[up_idx]          <= plru_touch(plru_reg[up_idx], up_vic);
            end
        end
    end

    // Tag and payload storage. It is written only on allocation.
    always_ff @(posedge clock) begin
        if (up_ok) begin
            tag_mem[up_idx][up_vic] <= up_tag;
            pos_mem[up_idx][up_vic] <= up_pos_i;
            typ_mem[up_idx][up_vic] <= up_typ_i;
            tar_mem[up_idx][up_vic] <= up_tar_i;
        end
    end

    // Registered lookup result. It holds when idle. A miss, or a lookup during a flush, gives all zeros.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_o     <= 1'b0;
            hit_way_o <= '0;
            br_pos_o  <= '0;
            br_typ_o  <= '0;
            br_tar_o  <= '0;
            br_dir_o  <= 1'b0;
        end else if (rd_vld_i) begin
            if (lookup_ok && rd_hit) begin
                hit_o     <= 1'b1;
                hit_way_o <= rd_way;
                br_pos_o  <= pos_mem[rd_idx][rd_way];
                br_typ_o  <= typ_mem[rd_idx][rd_way];
                br_tar_o  <= tar_mem[rd_idx][rd_way];
                br_dir_o  <= ctr_reg[rd_idx][rd_way][1];
            end else begin
                hit_o     <= 1'b0;
                hit_way_o <= '0;
                br_pos_o  <= '0;
                br_typ_o  <= '0;
                br_tar_o  <= '0;
                br_dir_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btb_nway.sv
// tb_btb_nway: directed testbench for btb_nway with default parameters (4 ways, 256 sets).
// Expected values are hand-computed.
module tb_btb_nway;

    localparam int SETS = 256;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        rd_vld_i;
    logic [63:0] rd_pc_i;
    logic        up_we_i;
    logic [63:0] up_pc_i;
    logic [2:0]  up_pos_i;
    logic [1:0]  up_typ_i;
    logic [63:0] up_tar_i;
    logic        rt_we_i;
    logic [63:0] rt_pc_i;
    logic        rt_dir_i;
    logic        flush_i;
    logic        busy_o;
    logic        hit_o;
    logic [1:0]  hit_way_o;
    logic [2:0]  br_pos_o;
    logic [1:0]  br_typ_o;
    logic [63:0] br_tar_o;
    logic        br_dir_o;

    int n_checks = 0;
    int n_errors = 0;

    btb_nway #(.WAYS(4), .SETS(SETS), .TAG_W(20)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_vld_i  (rd_vld_i),
        .rd_pc_i   (rd_pc_i),
        .up_we_i   (up_we_i),
        .up_pc_i   (up_pc_i),
        .up_pos_i  (up_pos_i),
        .up_typ_i  (up_typ_i),
        .up_tar_i  (up_tar_i),
        .rt_we_i   (rt_we_i),
        .rt_pc_i   (rt_pc_i),
        .rt_dir_i  (rt_dir_i),
        .flush_i   (flush_i),
        .busy_o    (busy_o),
        .hit_o     (hit_o),
        .hit_way_o (hit_way_o),
        .br_pos_o  (br_pos_o),
        .br_typ_o  (br_typ_o),
        .br_tar_o  (br_tar_o),
        .br_dir_o  (br_dir_o)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_alloc(input logic [63:0] pc, input logic [2:0] pos,
                            input logic [1:0] typ, input logic [63:0] tar);
        up_we_i = 1'b1; up_pc_i = pc; up_pos_i = pos; up_typ_i = typ; up_tar_i = tar;
        tick();
        up_we_i = 1'b0;
        $display("alloc  pc=0x%0h tar=0x%0h pos=%0d typ=%0d", pc, tar, pos, typ);
    endtask

    task automatic do_retire(input logic [63:0] pc, input logic dir);
        rt_we_i = 1'b1; rt_pc_i = pc; rt_dir_i = dir;
        tick();
        rt_we_i = 1'b0;
        $display("retire pc=0x%0h dir=%0d", pc, dir);
    endtask

    // Issue one lookup and compare the result; on expected miss all fields must be zero.
    task automatic lookup_chk(input string tag, input logic [63:0] pc, input logic exp_hit,
                              input logic [1:0] exp_way, input logic [2:0] exp_pos,
                              input logic [1:0] exp_typ, input logic [63:0] exp_tar,
                              input logic exp_dir);
        rd_vld_i = 1'b1; rd_pc_i = pc;
        tick();
        rd_vld_i = 1'b0;
        $display("lookup pc=0x%0h hit=%0d way=%0d tar=0x%0h dir=%0d",
                 pc, hit_o, hit_way_o, br_tar_o, br_dir_o);
        check({tag, ".hit"}, 64'(hit_o), 64'(exp_hit));
        check({tag, ".way"}, 64'(hit_way_o), 64'(exp_way));
        check({tag, ".pos"}, 64'(br_pos_o), 64'(exp_pos));
        check({tag, ".typ"}, 64'(br_typ_o), 64'(exp_typ));
        check({tag, ".tar"}, br_tar_o, exp_tar);
        check({tag, ".dir"}, 64'(br_dir_o), 64'(exp_dir));
    endtask

    task automatic expect_miss(input string tag, input logic [63:0] pc);
        lookup_chk(tag, pc, 1'b0, 2'd0, 3'd0, 2'd0, 64'h0, 1'b0);
    endtask

    // Set 5 PCs with tags 1..5: pc = (tag << 10) | (5 << 2)
    function automatic logic [63:0] set5_pc(input int t);
        return 64'((t << 10) | (5 << 2));
    endfunction

    int busy_cnt;

    initial begin
        reset_n = 1'b0;
        rd_vld_i = 0; rd_pc_i = 0; up_we_i = 0; up_pc_i = 0; up_pos_i = 0; up_typ_i = 0;
        up_tar_i = 0; rt_we_i = 0; rt_pc_i = 0; rt_dir_i = 0; flush_i = 0;
        repeat (3) tick();
        check("reset.busy", 64'(busy_o), 64'h0);
        check("reset.hit", 64'(hit_o), 64'h0);
        check("reset.tar", br_tar_o, 64'h0);
        reset_n = 1'b1;
        tick();

        // Basic allocate then lookup: way 0, counter weakly taken
        do_alloc(64'h1000, 3'd3, 2'd1, 64'h2000);
        lookup_chk("basic", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b1);
        tick();
        check("hold.hit", 64'(hit_o), 64'h1);
        check("hold.tar", br_tar_o, 64'h2000);

        // Counter walk: 2 ->1 ->0 ->0 ->1 ->2 ->3 ->3 ->2
        do_retire(64'h1000, 1'b0);
        lookup_chk("ctr1", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b0);
        do_retire(64'h1000, 1'b0);
        lookup_chk("ctr0", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b0);
        do_retire(64'h1000, 1'b0);
        lookup_chk("ctr0sat", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b0);
        do_retire(64'h1000, 1'b1);
        lookup_chk("ctr1up", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b0);
        do_retire(64'h1000, 1'b1);
        lookup_chk("ctr2up", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b1);
        do_retire(64'h1000, 1'b1);
        lookup_chk("ctr3up", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b1);
        do_retire(64'h1000, 1'b1);
        lookup_chk("ctr3sat", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b1);
        do_retire(64'h1000, 1'b0);
        lookup_chk("ctr2dn", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b1);
        do_retire(64'h5000, 1'b0);  // same set, other tag: miss changes nothing
        do_retire(64'h5000, 1'b0);
        lookup_chk("rtmiss", 64'h1000, 1'b1, 2'd0, 3'd3, 2'd1, 64'h2000, 1'b1);

        // Lookup and allocate in the same cycle: no bypass, then hit in free way 1
        rd_vld_i = 1'b1; rd_pc_i = 64'h3000;
        up_we_i = 1'b1; up_pc_i = 64'h3000; up_pos_i = 3'd5; up_typ_i = 2'd2; up_tar_i = 64'h3300;
        tick();
        rd_vld_i = 1'b0; up_we_i = 1'b0;
        $display("lookup+alloc pc=0x3000 hit=%0d", hit_o);
        check("nobypass.hit", 64'(hit_o), 64'h0);
        check("nobypass.tar", br_tar_o, 64'h0);
        lookup_chk("afterwr", 64'h3000, 1'b1, 2'd1, 3'd5, 2'd2, 64'h3300, 1'b1);

        // Overwrite way 0 while a not-taken retire hits it: retire dropped, counter 2
        up_we_i = 1'b1; up_pc_i = 64'h1000; up_pos_i = 3'd4; up_typ_i = 2'd3; up_tar_i = 64'h2400;
        rt_we_i = 1'b1; rt_pc_i = 64'h1000; rt_dir_i = 1'b0;
        tick();
        up_we_i = 1'b0; rt_we_i = 1'b0;
        $display("alloc+retire pc=0x1000");
        do_retire(64'h1000, 1'b0);  // 2 -> 1: dir falls to 0 only if the collision retire was dropped
        lookup_chk("collide", 64'h1000, 1'b1, 2'd0, 3'd4, 2'd3, 64'h2400, 1'b0);

        // PLRU replacement in set 5: ways 0..3 filled, way 0 touched, 5th tag replaces way 2
        for (int t = 1; t <= 4; t++)
            do_alloc(set5_pc(t), 3'(t), 2'd0, 64'(t * 256));
        lookup_chk("plru.touch", set5_pc(1), 1'b1, 2'd0, 3'd1, 2'd0, 64'h100, 1'b1);
        do_alloc(set5_pc(5), 3'd5, 2'd1, 64'h500);
        lookup_chk("plru.t1", set5_pc(1), 1'b1, 2'd0, 3'd1, 2'd0, 64'h100, 1'b1);
        lookup_chk("plru.t2", set5_pc(2), 1'b1, 2'd1, 3'd2, 2'd0, 64'h200, 1'b1);
        expect_miss("plru.t3gone", set5_pc(3));
        lookup_chk("plru.t4", set5_pc(4), 1'b1, 2'd3, 3'd4, 2'd0, 64'h400, 1'b1);
        lookup_chk("plru.t5", set5_pc(5), 1'b1, 2'd2, 3'd5, 2'd1, 64'h500, 1'b1);

        // Flush: busy for exactly SETS cycles; writes, re-flush and lookups during flush are ignored
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        $display("flush start busy=%0d", busy_o);
        busy_cnt = 0;
        while (busy_o && busy_cnt < SETS + 8) begin
            busy_cnt++;
            if (busy_cnt == 1) begin
                up_we_i = 1'b1; up_pc_i = 64'h7000; up_pos_i = 3'd1; up_typ_i = 2'd1; up_tar_i = 64'h7700;
                rd_vld_i = 1'b1; rd_pc_i = set5_pc(4);
                flush_i = 1'b1;
                tick();
                up_we_i = 1'b0; rd_vld_i = 1'b0; flush_i = 1'b0;
                check("flush.lookupmiss", 64'(hit_o), 64'h0);
            end else if (busy_cnt == 100) begin
                flush_i = 1'b1;
                tick();
                flush_i = 1'b0;
            end else begin
                tick();
            end
        end
        $display("flush end busy_cycles=%0d", busy_cnt);
        check("flush.cycles", 64'(busy_cnt), 64'(SETS));
        expect_miss("flush.m1000", 64'h1000);
        expect_miss("flush.m3000", 64'h3000);
        expect_miss("flush.mset5", set5_pc(4));
        expect_miss("flush.m7000", 64'h7000);

        // Reset during a flush and during a lookup: outputs drop without waiting for a clock edge
        do_alloc(64'h1000, 3'd2, 2'd1, 64'h9000);
        lookup_chk("prerst", 64'h1000, 1'b1, 2'd0, 3'd2, 2'd1, 64'h9000, 1'b1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        repeat (5) tick();
        check("rst.busybefore", 64'(busy_o), 64'h1);
        rd_vld_i = 1'b1; rd_pc_i = 64'h1000;
        #2;
        reset_n = 1'b0;
        #1;
        $display("async reset busy=%0d hit=%0d", busy_o, hit_o);
        check("rst.busy", 64'(busy_o), 64'h0);
        check("rst.hit", 64'(hit_o), 64'h0);
        check("rst.tar", br_tar_o, 64'h0);
        #10;
        rd_vld_i = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();
        check("rst.idle", 64'(busy_o), 64'h0);
        expect_miss("rst.m1000", 64'h1000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btb_nway.md
BTB_NWAY -- requirements
Module: btb_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity (power of 2, 2..8).
REQ-002 SHALL have parameter SETS, default 256, set count (power of 2, 16..1024); IDX_W = log2(SETS).
REQ-003 SHALL have parameter TAG_W, default 20, stored tag width.
REQ-004 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port rd_vld_i  input  1  lookup request.
REQ-007 SHALL have port rd_pc_i  input  64  lookup fetch PC.
REQ-008 SHALL have port up_we_i  input  1  allocate/overwrite request.
REQ-009 SHALL have ports up_pc_i 64, up_pos_i 3, up_typ_i 2, up_tar_i 64  inputs  branch PC, bundle position, type, target.
REQ-010 SHALL have ports rt_we_i 1, rt_pc_i 64, rt_dir_i 1  inputs  retire direction update.
REQ-011 SHALL have port flush_i  input  1  start full invalidation.
REQ-012 SHALL have port busy_o  output  1  flush in progress.
REQ-013 SHALL have ports hit_o 1, hit_way_o log2(WAYS), br_pos_o 3, br_typ_o 2, br_tar_o 64, br_dir_o 1  outputs  registered lookup result.

Function
REQ-014 SHALL derive index = pc[IDX_W+1:2] and tag = pc[IDX_W+TAG_W+1:IDX_W+2] for all three PC ports.
REQ-015 SHALL store per entry: valid, tag, pos, typ, tar, 2-bit saturating counter; per set: WAYS-1 tree-PLRU bits.
REQ-016 SHALL produce lookup result exactly one cycle after rd_vld_i; outputs hold their value when rd_vld_i=0.
REQ-017 SHALL signal hit when a valid way's tag matches; on multiple matches the lowest way index SHALL win.
REQ-018 SHALL on miss drive hit_o=0 and all other result outputs to 0.
REQ-019 SHALL drive br_dir_o = counter MSB of the hit way.
REQ-020 SHALL see pre-write array contents on a lookup in the same cycle as any write (no bypass).
REQ-021 SHALL on up_we_i select the victim: matching way if tag hits, else lowest invalid way, else PLRU victim.
REQ-022 SHALL on allocation write valid=1, tag, pos, typ, tar and counter=2'b10 (weakly taken); on overwrite of a matching way the counter SHALL also reset to 2'b10.
REQ-023 SHALL on rt_we_i with tag hit increment (rt_dir_i=1, saturate 3) or decrement (rt_dir_i=0, saturate 0) that way's counter; a miss SHALL change nothing.
REQ-024 SHALL, when up_we_i and rt_we_i target the same way of the same set, apply the allocation and drop the retire update.
REQ-025 SHALL update PLRU to point away from the used way on allocation and on a lookup hit; when both hit the same set in a cycle, allocation SHALL take precedence.
REQ-026 SHALL implement a two-state FSM IDLE/FLUSH: flush_i in IDLE -> FLUSH with counter=0; FLUSH clears valid and PLRU of set[counter] each cycle; counter=SETS-1 -> IDLE.
REQ-027 SHALL assert busy_o in FLUSH (SETS cycles exactly); flush_i during FLUSH SHALL be ignored.
REQ-028 SHALL during FLUSH ignore up_we_i and rt_we_i and return misses for lookups issued in FLUSH.

Reset
REQ-029 SHALL on reset_n=0 immediately clear all valid bits, counters, PLRU bits, FSM to IDLE, busy_o=0, and all result outputs to 0; tag/pos/typ/tar storage need not be reset.
REQ-030 SHALL abort an in-progress flush on reset and return to IDLE.

Verification
REQ-031 Alloc up_pc=0x1000, tar=0x2000, pos=3, typ=1; next cycle lookup 0x1000 -> one cycle later hit_o=1, br_tar_o=0x2000, br_pos_o=3, br_dir_o=1.
REQ-032 Retire rt_pc=0x1000 rt_dir=0 twice, then three times with dir=1 -> counter 2->1->0 (br_dir_o=0), then 1,2,3 (br_dir_o=1); fourth taken stays 3.
REQ-033 Fill one set with WAYS+1 distinct tags (WAYS=4), touching way 0 by lookup before 5th alloc -> way 0 survives, PLRU victim replaced, earlier tags still hit.
REQ-034 Lookup and alloc same PC in same cycle -> lookup returns miss; repeat lookup next cycle -> hit.
REQ-035 Assert flush_i after filling entries -> busy_o=1 for exactly SETS cycles, writes during flush dropped, all later lookups miss.
REQ-036 Pulse reset_n=0 mid-flush and mid-lookup -> busy_o and hit_o drop to 0 asynchronously; post-reset lookups miss.
